uart_eeprom_cmd: RTL and testbench
==================================

// Module: uart_eeprom_cmd
// PURPOSE
//  Command sequencer between uart_ctrl and the IIC EEPROM engine. Parses framed host commands from the
//  rx byte stream, issues one EEPROM read/write transaction and returns a response over uart tx.
//  It paces tx_en itself, because the uart tx path has no busy flag. Sits in the top level beside
//  uart_ctrl and the IIC master.
// PARAMETERS
//  TX_GAP      2200    min clk cycles between tx_en pulses (>= 10 bit times at baud_div 216)
//  RX_TIMEOUT  500000  idle clk cycles mid-frame before the partial frame is discarded
//  EE_TIMEOUT  2500000 clk cycles allowed from ee_req rise to ee_done before the request is aborted
//  CNT_W       22      width of the shared timeout/gap counter; must hold max(TX_GAP,RX_TIMEOUT,EE_TIMEOUT)
// PORTS
//  clk       in   1  system clock, 50 MHz
//  rst_n     in   1  synchronous reset, active low
//  rx_dat    in   8  received byte, valid when rx_rdy=1
//  rx_rdy    in   1  1-cycle pulse: new rx byte
//  tx_en     out  1  1-cycle pulse: start sending tx_dat
//  tx_dat    out  8  byte to send; held stable until the next tx_en
//  ee_req    out  1  EEPROM request, held high until ee_done or timeout
//  ee_wr     out  1  1=write, 0=read; stable while ee_req=1
//  ee_addr   out  8  EEPROM byte address; stable while ee_req=1
//  ee_wdat   out  8  write data; stable while ee_req=1
//  ee_rdat   in   8  read data, valid in the ee_done cycle
//  ee_done   in   1  1-cycle pulse: transaction complete
//  busy      out  1  1 in every state except S_HDR
//  rx_drop   out  1  1-cycle pulse: rx byte ignored (arrived in S_EE/S_TX*/S_GAP)
// BEHAVIOUR
//  - Frame: 0x55, CMD, ADDR[, DATA]. CMD 0x01 = write (DATA follows), 0x02 = read (no DATA).
//  - Responses: write ok -> 0xAA. Read ok -> 0xAA then the data byte. Bad CMD or EE timeout -> 0xEE.
//  - Reset: all outputs 0, tx_dat=8'h00, state S_HDR, counter 0.
//  - FSM:
//    - S_HDR: rx 0x55 -> S_CMD. Any other byte is discarded silently, without rx_drop.
//    - S_CMD: 0x01/0x02 latch cmd -> S_ADDR. Any other value -> S_TX0 with resp 0xEE.
//    - S_ADDR: latch ee_addr. Write -> S_DATA, read -> S_EE.
//    - S_DATA: latch ee_wdat -> S_EE.
//    - S_EE: ee_req=1 from the cycle after entry. On ee_done: ee_req=0 in the next cycle, capture
//      ee_rdat, go to S_TX0 with resp 0xAA. If the counter reaches EE_TIMEOUT: ee_req=0, resp 0xEE -> S_TX0.
//    - S_TX0: one cycle. tx_en=1, tx_dat=resp, counter cleared. Then a read with resp 0xAA -> S_GAP then
//      S_TX1; otherwise -> S_GAP then S_HDR.
//    - S_TX1: one cycle. tx_en=1, tx_dat=captured rdat -> S_GAP then S_HDR.
//    - S_GAP: wait TX_GAP cycles after each tx_en, so pulses are exactly TX_GAP+1 cycles apart.
//  - RX timeout: in S_CMD/S_ADDR/S_DATA the counter is cleared on each rx_rdy. At RX_TIMEOUT -> S_HDR,
//    latched fields dropped, no response sent.
//  - Latency: ee_req rises 1 cycle after the final frame byte's rx_rdy. tx_en fires 2 cycles after ee_done.
//  - rx_rdy in S_EE, S_TX0, S_TX1 or S_GAP: byte dropped, rx_drop=1 in the same cycle, FSM unaffected.
//  - ee_done outside S_EE is ignored. ee_done in the same cycle as the timeout: ee_done wins (success path).
//  - tx_en and ee_req are never asserted in the same cycle.
//  - Reset mid-transaction: ee_req falls on the reset cycle. The IIC master must tolerate an abandoned request.
//  - Counter saturates and never wraps. Compare with >=.
// STRUCTURE
//  - Shared package (uart_eeprom_pkg.vh):
//    - state encodings S_HDR..S_GAP (3 bits)
//    - constants HDR=8'h55, CMD_WR=8'h01, CMD_RD=8'h02, RSP_OK=8'hAA, RSP_ERR=8'hEE
//  - Single always block FSM plus one CNT_W counter, shared by the gap, rx-timeout and ee-timeout functions.
//  - No sub-module. uart_ctrl and the IIC master are instantiated by the parent.
// TESTING
//  1. rx 55 01 10 5A -> ee_req=1, ee_wr=1, ee_addr=0x10, ee_wdat=0x5A; ee_done after 100 clk -> one tx_en with tx_dat=0xAA.
//  2. rx 55 02 3F; ee_rdat=0xC3 with ee_done -> tx_en 0xAA, then exactly TX_GAP+1 cycles later tx_en 0xC3; busy=0 after the gap.
//  3. rx 55 07 -> tx 0xEE, no ee_req ever; then rx 55 02 00 is accepted normally.
//  4. rx 55 01 then idle RX_TIMEOUT cycles -> back to S_HDR, no tx_en; later rx 10 5A is ignored (no ee_req).
//  5. ee_done withheld -> ee_req drops at EE_TIMEOUT, tx 0xEE. Bytes rx'd during S_EE each pulse rx_drop.
//  6. Garbage 00 FF 55 02 20 -> single read of addr 0x20. rst_n=0 while ee_req=1 -> ee_req=0 on the next edge, all outputs at reset values.

Source files
------------

// File: rtl/uart_eeprom_pkg.sv
// ============================================================================
// Module      : uart_eeprom_pkg
// Description : State encodings and protocol byte constants shared by the
//               UART-to-EEPROM command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_eeprom_pkg;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_EE   = 3'd4,
        S_TX0  = 3'd5,
        S_TX1  = 3'd6,
        S_GAP  = 3'd7
    } state_t;

    localparam logic [7:0] HDR     = 8'h55;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RSP_OK  = 8'hAA;
    localparam logic [7:0] RSP_ERR = 8'hEE;

endpackage

`default_nettype wire

// File: rtl/uart_eeprom_cmd.sv
// ============================================================================
// Module      : uart_eeprom_cmd
// Description : Parses framed host commands from the UART rx stream, runs one
//               EEPROM read/write and paces the response bytes onto UART tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_eeprom_cmd
    import uart_eeprom_pkg::*;
#(
    parameter int unsigned TX_GAP     = 2200,
    parameter int unsigned RX_TIMEOUT = 500000,
    parameter int unsigned EE_TIMEOUT = 2500000,
    parameter int unsigned CNT_W      = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_dat,
    input  logic       rx_rdy,
    output logic       tx_en,
    output logic [7:0] tx_dat,
    output logic       ee_req,
    output logic       ee_wr,
    output logic [7:0] ee_addr,
    output logic [7:0] ee_wdat,
    input  logic [7:0] ee_rdat,
    input  logic       ee_done,
    output logic       busy,
    output logic       rx_drop
);

    // Each limit is the last count value before the event fires, so the
    // guarded interval lasts exactly the parameter's number of cycles.
    localparam logic [CNT_W-1:0] c_gap_last = CNT_W'(TX_GAP - 1);
    localparam logic [CNT_W-1:0] c_rx_last  = CNT_W'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ee_last  = CNT_W'(EE_TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_resp;
    logic [7:0]       r_rdat;
    logic             r_more;
    logic             r_tx_en;
    logic [7:0]       r_tx_dat;
    logic             r_ee_req;
    logic             r_ee_wr;
    logic [7:0]       r_ee_addr;
    logic [7:0]       r_ee_wdat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_HDR;
            r_cnt     <= '0;
            r_resp    <= 8'h00;
            r_rdat    <= 8'h00;
            r_more    <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_dat  <= 8'h00;
            r_ee_req  <= 1'b0;
            r_ee_wr   <= 1'b0;
            r_ee_addr <= 8'h00;
            r_ee_wdat <= 8'h00;
        end else begin
            r_tx_en <= 1'b0;
            case (r_state)
                S_HDR: begin
                    r_cnt <= '0;
                    if (rx_rdy && rx_dat == HDR)
                        r_state <= S_CMD;
                end

                S_CMD, S_ADDR, S_DATA: begin
                    if (rx_rdy) begin
                        r_cnt <= '0;
                        case (r_state)
                            S_CMD: begin
                                if (rx_dat == CMD_WR || rx_dat == CMD_RD) begin
                                    r_ee_wr <= (rx_dat == CMD_WR);
                                    r_state <= S_ADDR;
                                end else begin
                                    r_ee_wr <= 1'b0;
                                    r_resp  <= RSP_ERR;
                                    r_state <= S_TX0;
                                end
                            end
                            S_ADDR: begin
                                r_ee_addr <= rx_dat;
                                if (r_ee_wr) begin
                                    r_state <= S_DATA;
                                end else begin
                                    r_ee_req <= 1'b1;
                                    r_state  <= S_EE;
                                end
                            end
                            default: begin
                                r_ee_wdat <= rx_dat;
                                r_ee_req  <= 1'b1;
                                r_state   <= S_EE;
                            end
                        endcase
                    end else if (r_cnt >= c_rx_last) begin
                        // Host went quiet mid-frame: forget the partial command.
                        r_cnt     <= '0;
                        r_ee_wr   <= 1'b0;
                        r_ee_addr <= 8'h00;
                        r_ee_wdat <= 8'h00;
                        r_state   <= S_HDR;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_EE: begin
                    if (ee_done) begin
                        r_ee_req <= 1'b0;
                        r_rdat   <= ee_rdat;
                        r_resp   <= RSP_OK;
                        r_state  <= S_TX0;
                    end else if (r_cnt >= c_ee_last) begin
                        r_ee_req <= 1'b0;
                        r_resp   <= RSP_ERR;
                        r_state  <= S_TX0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_TX0: begin
                    r_tx_en  <= 1'b1;
                    r_tx_dat <= r_resp;
                    r_cnt    <= '0;
                    r_more   <= !r_ee_wr && (r_resp == RSP_OK);
                    r_state  <= S_GAP;
                end

                S_TX1: begin
                    r_tx_en  <= 1'b1;
                    r_tx_dat <= r_rdat;
                    r_cnt    <= '0;
                    r_more   <= 1'b0;
                    r_state  <= S_GAP;
                end

                S_GAP: begin
                    if (r_cnt >= c_gap_last)
                        r_state <= r_more ? S_TX1 : S_HDR;
                    else if (r_cnt != '1)
                        r_cnt <= r_cnt + 1'b1;
                end

                default: r_state <= S_HDR;
            endcase
        end
    end

    assign tx_en   = r_tx_en;
    assign tx_dat  = r_tx_dat;
    assign ee_req  = r_ee_req;
    assign ee_wr   = r_ee_wr;
    assign ee_addr = r_ee_addr;
    assign ee_wdat = r_ee_wdat;
    assign busy    = (r_state != S_HDR);
    // Drop must be flagged in the same cycle the byte is offered.
    assign rx_drop = rx_rdy && (r_state inside {S_EE, S_TX0, S_TX1, S_GAP});

endmodule

`default_nettype wire

// File: tb/tb_uart_eeprom_cmd.sv
// ============================================================================
// Module      : tb_uart_eeprom_cmd
// Description : Directed self-checking bench for uart_eeprom_cmd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_eeprom_cmd;

    localparam int TX_GAP     = 20;
    localparam int RX_TIMEOUT = 40;
    localparam int EE_TIMEOUT = 200;
    localparam int CNT_W      = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_dat;
    logic       rx_rdy;
    logic       tx_en;
    logic [7:0] tx_dat;
    logic       ee_req;
    logic       ee_wr;
    logic [7:0] ee_addr;
    logic [7:0] ee_wdat;
    logic [7:0] ee_rdat;
    logic       ee_done;
    logic       busy;
    logic       rx_drop;

    int n_cmp = 0;
    int n_err = 0;

    int         cyc = 0;
    int         tx_cyc[$];
    logic [7:0] tx_val[$];
    int         ee_rises = 0;
    int         overlap = 0;
    logic       prev_req = 1'b0;
    int         base;

    uart_eeprom_cmd #(
        .TX_GAP     (TX_GAP),
        .RX_TIMEOUT (RX_TIMEOUT),
        .EE_TIMEOUT (EE_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_dat  (rx_dat),
        .rx_rdy  (rx_rdy),
        .tx_en   (tx_en),
        .tx_dat  (tx_dat),
        .ee_req  (ee_req),
        .ee_wr   (ee_wr),
        .ee_addr (ee_addr),
        .ee_wdat (ee_wdat),
        .ee_rdat (ee_rdat),
        .ee_done (ee_done),
        .busy    (busy),
        .rx_drop (rx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tx_en) begin
            tx_cyc.push_back(cyc);
            tx_val.push_back(tx_dat);
        end
        if (ee_req && !prev_req) ee_rises = ee_rises + 1;
        if (tx_en && ee_req) overlap = overlap + 1;
        prev_req = ee_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_drop);
        rx_dat = b;
        rx_rdy = 1'b1;
        #1;
        chk($sformatf("rx_drop_%02h", b), rx_drop, exp_drop);
        tick();
        rx_rdy = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_dat  = 8'h00;
        rx_rdy  = 1'b0;
        ee_done = 1'b0;
        ee_rdat = 8'h00;
        repeat (3) tick();
        chk("rst_tx_en",   tx_en,   0);
        chk("rst_tx_dat",  tx_dat,  0);
        chk("rst_ee_req",  ee_req,  0);
        chk("rst_ee_wr",   ee_wr,   0);
        chk("rst_ee_addr", ee_addr, 0);
        chk("rst_ee_wdat", ee_wdat, 0);
        chk("rst_busy",    busy,    0);
        rst_n = 1'b1;
        tick();

        // Write 0x5A to 0x10, done after 100 cycles
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        send_byte(8'h5A, 0);
        chk("t1_ee_req",  ee_req,  1);
        chk("t1_ee_wr",   ee_wr,   1);
        chk("t1_ee_addr", ee_addr, 8'h10);
        chk("t1_ee_wdat", ee_wdat, 8'h5A);
        chk("t1_busy",    busy,    1);
        repeat (99) tick();
        chk("t1_req_held", ee_req, 1);
        ee_done = 1'b1;
        ee_rdat = 8'h77;
        tick();
        ee_done = 1'b0;
        chk("t1_req_drop", ee_req, 0);
        chk("t1_tx_early", tx_en,  0);
        tick();
        chk("t1_tx_en",  tx_en,  1);
        chk("t1_tx_dat", tx_dat, 8'hAA);
        repeat (TX_GAP - 1) tick();
        chk("t1_busy_gap", busy, 1);
        tick();
        chk("t1_busy_end", busy, 0);
        chk("t1_tx_count", tx_cyc.size(), 1);

        // Read 0x3F returning 0xC3
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'h3F, 0);
        chk("t2_ee_req",  ee_req,  1);
        chk("t2_ee_wr",   ee_wr,   0);
        chk("t2_ee_addr", ee_addr, 8'h3F);
        repeat (3) tick();
        ee_done = 1'b1;
        ee_rdat = 8'hC3;
        tick();
        ee_done = 1'b0;
        ee_rdat = 8'h00;
        tick();
        chk("t2_tx0_en",  tx_en,  1);
        chk("t2_tx0_dat", tx_dat, 8'hAA);
        repeat (TX_GAP) tick();
        chk("t2_tx_quiet", tx_en, 0);
        tick();
        chk("t2_tx1_en",  tx_en,  1);
        chk("t2_tx1_dat", tx_dat, 8'hC3);
        repeat (TX_GAP - 1) tick();
        chk("t2_busy_gap", busy, 1);
        tick();
        chk("t2_busy_end", busy, 0);
        chk("t2_tx_count", tx_cyc.size(), 3);
        chk("t2_spacing", tx_cyc[2] - tx_cyc[1], TX_GAP + 1);

        // Bad command, then a normal read
        send_byte(8'h55, 0);
        send_byte(8'h07, 0);
        chk("t3_no_req", ee_req, 0);
        tick();
        chk("t3_tx_en",  tx_en,  1);
        chk("t3_tx_dat", tx_dat, 8'hEE);
        repeat (TX_GAP) tick();
        chk("t3_busy_end", busy, 0);
        chk("t3_rises", ee_rises, 2);
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        chk("t3_rd_req",  ee_req,  1);
        chk("t3_rd_wr",   ee_wr,   0);
        chk("t3_rd_addr", ee_addr, 8'h00);
        repeat (2) tick();
        ee_done = 1'b1;
        ee_rdat = 8'h5C;
        tick();
        ee_done = 1'b0;
        repeat (2 * (TX_GAP + 1) + 2) tick();
        chk("t3_busy_idle", busy, 0);
        chk("t3_tx_count", tx_cyc.size(), 6);
        chk("t3_tx_last",  tx_val[5], 8'h5C);

        // Rx timeout mid-frame; stragglers are ignored
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        repeat (RX_TIMEOUT - 1) tick();
        chk("t4_busy_wait", busy, 1);
        tick();
        chk("t4_busy_hdr", busy, 0);
        send_byte(8'h10, 0);
        send_byte(8'h5A, 0);
        tick();
        chk("t4_no_req",   ee_req, 0);
        chk("t4_busy",     busy,   0);
        chk("t4_tx_count", tx_cyc.size(), 6);

        // EE timeout with bytes arriving during S_EE and the gap
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'h44, 0);
        chk("t5_ee_req", ee_req, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        chk("t5_req_kept", ee_req, 1);
        repeat (EE_TIMEOUT - 3) tick();
        chk("t5_req_last", ee_req, 1);
        tick();
        chk("t5_req_abort", ee_req, 0);
        chk("t5_tx_early",  tx_en,  0);
        tick();
        chk("t5_tx_en",  tx_en,  1);
        chk("t5_tx_dat", tx_dat, 8'hEE);
        send_byte(8'h56, 1);
        repeat (TX_GAP - 2) tick();
        chk("t5_busy_gap", busy, 1);
        tick();
        chk("t5_busy_end", busy, 0);

        // Garbage before header, then reset while the request is pending
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        chk("t6_ee_req",  ee_req,  1);
        chk("t6_ee_wr",   ee_wr,   0);
        chk("t6_ee_addr", ee_addr, 8'h20);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_req",    ee_req,  0);
        chk("t6_rst_tx_en",  tx_en,   0);
        chk("t6_rst_tx_dat", tx_dat,  0);
        chk("t6_rst_addr",   ee_addr, 0);
        chk("t6_rst_wdat",   ee_wdat, 0);
        chk("t6_rst_busy",   busy,    0);
        rst_n = 1'b1;
        repeat (2) tick();

        chk("tx_total",   tx_cyc.size(), 7);
        chk("ee_rises",   ee_rises, 5);
        chk("no_overlap", overlap,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
